// File: rtl/result_drain_pkg.sv
// Shared types and constants for the result-SRAM drain path.
// Widths match the TPU write-out side: ARRAY_SIZE elements per row, OUTPUT_DATA_WIDTH bits each,
// ROWS_PER_SET rows per result set, addressed with MATRIX_BITS.
package result_drain_pkg;

  localparam int ARRAY_SIZE        = 8;
  localparam int OUTPUT_DATA_WIDTH = 16;
  localparam int MATRIX_BITS       = 6;
  localparam int ROWS_PER_SET      = 2 * ARRAY_SIZE - 1;
  localparam int ROW_DATA_W        = ARRAY_SIZE * OUTPUT_DATA_WIDTH;

  localparam logic [1:0] SET_A = 2'd0;
  localparam logic [1:0] SET_B = 2'd1;
  localparam logic [1:0] SET_C = 2'd2;

  localparam logic [MATRIX_BITS-1:0] LAST_ROW = MATRIX_BITS'(ROWS_PER_SET - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } drain_state_t;

  typedef struct packed {
    logic [ROW_DATA_W-1:0]  data;
    logic [1:0]             set;
    logic [MATRIX_BITS-1:0] row;
    logic                   last;
  } beat_t;

  // Wrap-around sum of the signed elements of one row.
  function automatic logic [31:0] row_sum(input logic [ROW_DATA_W-1:0] d);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      s = s + 32'(signed'(d[i*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH]));
    end
    return s;
  endfunction

endpackage

// File: rtl/result_drain_if.sv
// Row-beat stream from the drain block toward the host/checker.
// Ports: out_valid/out_ready handshake; out_data row payload, out_set (0=a,1=b,2=c), out_row, out_last.
// master drives the beat, slave drives out_ready.
interface result_drain_if;
  import result_drain_pkg::*;

  logic                   out_valid;
  logic                   out_ready;
  logic [ROW_DATA_W-1:0]  out_data;
  logic [1:0]             out_set;
  logic [MATRIX_BITS-1:0] out_row;
  logic                   out_last;

  modport master (output out_valid, out_data, out_set, out_row, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_set, out_row, out_last, output out_ready);

endinterface

// File: rtl/result_drain_fifo2.sv
// 2-entry FIFO of beat_t with synchronous active-high clear.
// Latency: push visible at head the cycle after the push edge. Push+pop when full is legal.
// Ports: clk, clr, push/push_dat, pop, head (current oldest entry), count (0..2).
module drain_fifo2
  import result_drain_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       push,
  input  beat_t      push_dat,
  input  logic       pop,
  output beat_t      head,
  output logic [1:0] count
);

  beat_t mem [2];
  logic  wr_ptr;
  logic  rd_ptr;

  always_ff @(posedge clk) begin
    if (clr) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      // When full with a simultaneous pop, wr_ptr == rd_ptr, so the new beat
      // lands in the slot being vacated.
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/result_drain.sv
// Reads result sets a, b, c row by row from the result SRAMs and streams each row as one beat.
// Latency: start sampled at edge N -> first strobe in the following cycle -> out_valid after edge N+2.
// Backpressure: credit rule keeps at most 2 beats issued-but-unaccepted; reads stall while out_ready is low.
// Ports: clk, srst (sync, active-high), drain_start, sram_read_enable_{a0,b0,c0}, sram_raddr,
//        sram_rdata_{a,b,c}, out_s (beat stream), drain_busy, drain_done,
//        drain_sum (only when RESULT_DRAIN_SUM_EN is defined).
module result_drain
  import result_drain_pkg::*;
(
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   drain_start,
  output logic                   sram_read_enable_a0,
  output logic                   sram_read_enable_b0,
  output logic                   sram_read_enable_c0,
  output logic [MATRIX_BITS-1:0] sram_raddr,
  input  logic [ROW_DATA_W-1:0]  sram_rdata_a,
  input  logic [ROW_DATA_W-1:0]  sram_rdata_b,
  input  logic [ROW_DATA_W-1:0]  sram_rdata_c,
  result_drain_if.master         out_s,
  output logic                   drain_busy,
  output logic                   drain_done
`ifdef RESULT_DRAIN_SUM_EN
  ,
  output logic [31:0]            drain_sum
`endif
);

  drain_state_t           state_q, state_d;
  logic [1:0]             set_q;
  logic [MATRIX_BITS-1:0] row_q;
  logic [MATRIX_BITS-1:0] raddr_q;
  logic                   inflight_q;
  logic [1:0]             tag_set_q;
  logic [MATRIX_BITS-1:0] tag_row_q;
  logic                   tag_last_q;

  logic [1:0] fifo_count;
  beat_t      head;
  beat_t      push_beat;
  logic       pop;
  logic       issue;
  logic       issue_last;
  logic       start_acc;
  logic       flush_empty;

  assign pop       = out_s.out_valid & out_s.out_ready;
  assign start_acc = (state_q == IDLE) && drain_start;

  // A read may only be issued if, after this cycle's pop, fewer than two beats
  // are held in the FIFO or on their way from the SRAM.
  assign issue      = (state_q == READ) &&
                      (({1'b0, fifo_count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
  assign issue_last = issue && (set_q == SET_C) && (row_q == LAST_ROW);

  // Look ahead through this cycle's pop so drain_done lands one cycle after the final handshake.
  assign flush_empty = !inflight_q && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop));

  // State register
  always_ff @(posedge clk) begin
    if (srst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (drain_start) state_d = READ;
      READ:    if (issue_last)  state_d = FLUSH;
      FLUSH:   if (flush_empty) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    drain_busy          = (state_q == READ) || (state_q == FLUSH);
    drain_done          = (state_q == DONE);
    sram_read_enable_a0 = issue && (set_q == SET_A);
    sram_read_enable_b0 = issue && (set_q == SET_B);
    sram_read_enable_c0 = issue && (set_q == SET_C);
  end

  assign sram_raddr = issue ? row_q : raddr_q;

  // Row/set walker and the one-cycle response tag
  always_ff @(posedge clk) begin
    if (srst) begin
      set_q      <= SET_A;
      row_q      <= '0;
      raddr_q    <= '0;
      inflight_q <= 1'b0;
      tag_set_q  <= SET_A;
      tag_row_q  <= '0;
      tag_last_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (start_acc) begin
        set_q <= SET_A;
        row_q <= '0;
      end else if (issue) begin
        raddr_q    <= row_q;
        tag_set_q  <= set_q;
        tag_row_q  <= row_q;
        tag_last_q <= issue_last;
        if (row_q == LAST_ROW) begin
          row_q <= '0;
          set_q <= set_q + 2'd1;
        end else begin
          row_q <= row_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    push_beat.set  = tag_set_q;
    push_beat.row  = tag_row_q;
    push_beat.last = tag_last_q;
    case (tag_set_q)
      SET_A:   push_beat.data = sram_rdata_a;
      SET_B:   push_beat.data = sram_rdata_b;
      default: push_beat.data = sram_rdata_c;
    endcase
  end

  drain_fifo2 u_fifo (
    .clk      (clk),
    .clr      (srst),
    .push     (inflight_q),
    .push_dat (push_beat),
    .pop      (pop),
    .head     (head),
    .count    (fifo_count)
  );

  assign out_s.out_valid = (fifo_count != 2'd0);
  assign out_s.out_data  = head.data;
  assign out_s.out_set   = head.set;
  assign out_s.out_row   = head.row;
  assign out_s.out_last  = head.last;

`ifdef RESULT_DRAIN_SUM_EN
  always_ff @(posedge clk) begin
    if (srst || start_acc) drain_sum <= '0;
    else if (pop)          drain_sum <= drain_sum + row_sum(head.data);
  end
`endif

endmodule

// File: tb/tb_result_drain.sv
// Bench for result_drain: SRAM model with 1-cycle read latency, handshake monitor,
// and per-scenario tasks comparing the beat stream against the expected a/b/c row order.
module tb_result_drain;
  import result_drain_pkg::*;

  localparam int TOTAL = 3 * ROWS_PER_SET;

  logic clk = 1'b0;
  logic srst;
  logic drain_start;
  logic sram_read_enable_a0, sram_read_enable_b0, sram_read_enable_c0;
  logic [MATRIX_BITS-1:0] sram_raddr;
  logic [ROW_DATA_W-1:0] sram_rdata_a, sram_rdata_b, sram_rdata_c;
  logic drain_busy, drain_done;
`ifdef RESULT_DRAIN_SUM_EN
  logic [31:0] drain_sum;
`endif

  result_drain_if ifc ();

  result_drain dut (
    .clk                 (clk),
    .srst                (srst),
    .drain_start         (drain_start),
    .sram_read_enable_a0 (sram_read_enable_a0),
    .sram_read_enable_b0 (sram_read_enable_b0),
    .sram_read_enable_c0 (sram_read_enable_c0),
    .sram_raddr          (sram_raddr),
    .sram_rdata_a        (sram_rdata_a),
    .sram_rdata_b        (sram_rdata_b),
    .sram_rdata_c        (sram_rdata_c),
    .out_s               (ifc),
    .drain_busy          (drain_busy),
    .drain_done          (drain_done)
`ifdef RESULT_DRAIN_SUM_EN
    ,
    .drain_sum           (drain_sum)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM contents and read model; unstrobed cycles return garbage.
  logic [ROW_DATA_W-1:0] mem_a [ROWS_PER_SET];
  logic [ROW_DATA_W-1:0] mem_b [ROWS_PER_SET];
  logic [ROW_DATA_W-1:0] mem_c [ROWS_PER_SET];

  function automatic logic [ROW_DATA_W-1:0] rnd_row();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(posedge clk) begin
    sram_rdata_a <= (sram_read_enable_a0 && sram_raddr < ROWS_PER_SET) ? mem_a[sram_raddr] : rnd_row();
    sram_rdata_b <= (sram_read_enable_b0 && sram_raddr < ROWS_PER_SET) ? mem_b[sram_raddr] : rnd_row();
    sram_rdata_c <= (sram_read_enable_c0 && sram_raddr < ROWS_PER_SET) ? mem_c[sram_raddr] : rnd_row();
  end

  function automatic logic [ROW_DATA_W-1:0] exp_data(input int s, input int r);
    case (s)
      0:       return mem_a[r];
      1:       return mem_b[r];
      default: return mem_c[r];
    endcase
  endfunction

  // Monitor: records accepted beats and counts protocol violations.
  typedef struct {
    int                    set;
    int                    row;
    logic [ROW_DATA_W-1:0] data;
    logic                  last;
    int                    cyc;
  } rec_t;

  rec_t got[$];
  logic mon_clr = 1'b0;
  int issued, accepted, credit_err, stable_err, multi_err;
  int first_strobe_cyc, done_cyc, done_pulses, busy_rise_cyc;
  logic busy_at_done;
  logic [31:0] sum_at_done;
  int m_ns;
  logic m_pop, prev_stall;
  logic [ROW_DATA_W-1:0] prev_data;
  logic [1:0] prev_set;
  logic [MATRIX_BITS-1:0] prev_row;
  logic prev_last;

  always @(negedge clk) begin
    if (mon_clr || srst) begin
      if (mon_clr) begin
        got.delete();
        issued = 0; accepted = 0; credit_err = 0; stable_err = 0; multi_err = 0;
        first_strobe_cyc = -1; done_cyc = -1; done_pulses = 0; busy_rise_cyc = -1;
        busy_at_done = 1'b0; sum_at_done = '0;
      end
      prev_stall = 1'b0;
    end else begin
      m_ns  = int'(sram_read_enable_a0) + int'(sram_read_enable_b0) + int'(sram_read_enable_c0);
      m_pop = ifc.out_valid & ifc.out_ready;
      if (m_ns > 1) multi_err++;
      if (m_ns == 1) begin
        if (issued - accepted - int'(m_pop) >= 2) credit_err++;
        if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
        issued++;
      end
      if (prev_stall && (ifc.out_valid !== 1'b1 || ifc.out_data !== prev_data ||
                         ifc.out_set !== prev_set || ifc.out_row !== prev_row ||
                         ifc.out_last !== prev_last))
        stable_err++;
      prev_stall = ifc.out_valid & ~ifc.out_ready;
      prev_data = ifc.out_data; prev_set = ifc.out_set; prev_row = ifc.out_row; prev_last = ifc.out_last;
      if (m_pop) begin
        got.push_back('{int'(ifc.out_set), int'(ifc.out_row), ifc.out_data, ifc.out_last, cyc});
        accepted++;
      end
      if (drain_busy && busy_rise_cyc < 0) busy_rise_cyc = cyc;
      if (drain_done) begin
        done_cyc = cyc;
        done_pulses++;
        busy_at_done = drain_busy;
`ifdef RESULT_DRAIN_SUM_EN
        sum_at_done = drain_sum;
`endif
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int start_cyc;

  task automatic mon_clear();
    @(posedge clk); #1;
    mon_clr = 1'b1;
    @(negedge clk); #1;
    mon_clr = 1'b0;
  endtask

  task automatic fill_mem(input bit all_ones);
    for (int r = 0; r < ROWS_PER_SET; r++) begin
      mem_a[r] = all_ones ? '1 : rnd_row();
      mem_b[r] = all_ones ? '1 : rnd_row();
      mem_c[r] = all_ones ? '1 : rnd_row();
    end
  endtask

  // mode 0: ready high; 1: ready low on cycles 5..9; 2: random ready; 3: re-pulse start at beat 10
  task automatic run_drain(input int mode, output bit timed_out);
    bit fired;
    int rel;
    fired = 1'b0;
    timed_out = 1'b1;
    @(posedge clk); #1;
    drain_start = 1'b1;
    start_cyc = cyc;
    ifc.out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      drain_start = 1'b0;
      rel = cyc - start_cyc;
      case (mode)
        1:       ifc.out_ready = !(rel >= 5 && rel <= 9);
        2:       ifc.out_ready = 1'($urandom_range(0, 1));
        default: ifc.out_ready = 1'b1;
      endcase
      if (mode == 3 && !fired && accepted >= 10) begin
        drain_start = 1'b1;
        fired = 1'b1;
      end
      if (done_pulses > 0) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    srst = 1'b1; drain_start = 1'b0; ifc.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({sram_read_enable_a0, sram_read_enable_b0, sram_read_enable_c0} !== 3'b000 || sram_raddr !== '0) begin
      errors++; $display("FAIL reset_sram strobes=%b raddr=%0d want 000/0",
        {sram_read_enable_a0, sram_read_enable_b0, sram_read_enable_c0}, sram_raddr);
    end
    checks++;
    if (ifc.out_valid !== 1'b0 || ifc.out_data !== '0 || ifc.out_set !== 2'd0 ||
        ifc.out_row !== '0 || ifc.out_last !== 1'b0) begin
      errors++; $display("FAIL reset_stream valid=%b set=%0d row=%0d last=%b data=%h want all 0",
        ifc.out_valid, ifc.out_set, ifc.out_row, ifc.out_last, ifc.out_data);
    end
    checks++;
    if (drain_busy !== 1'b0 || drain_done !== 1'b0) begin
      errors++; $display("FAIL reset_status busy=%b done=%b want 0/0", drain_busy, drain_done);
    end
    @(posedge clk); #1;
    srst = 1'b0;
    ifc.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (drain_busy !== 1'b0 || ifc.out_valid !== 1'b0 || sram_read_enable_a0 !== 1'b0) begin
      errors++; $display("FAIL reset_idle busy=%b valid=%b strobe_a=%b want 0/0/0",
        drain_busy, ifc.out_valid, sram_read_enable_a0);
    end
  endtask

  task automatic test_full_rate();
    bit to;
    fill_mem(1'b0);
    mon_clear();
    run_drain(0, to);
    checks++;
    if (to) begin errors++; $display("FAIL full_timeout done not seen want done pulse"); end
    for (int k = 0; k < TOTAL; k++) begin
      checks++;
      if (k >= got.size()) begin
        errors++; $display("FAIL full_beat%0d missing got %0d beats want %0d", k, got.size(), TOTAL);
      end else if (got[k].set != k / ROWS_PER_SET || got[k].row != k % ROWS_PER_SET ||
                   got[k].last !== (k == TOTAL - 1) || got[k].cyc != start_cyc + 3 + k ||
                   got[k].data !== exp_data(k / ROWS_PER_SET, k % ROWS_PER_SET)) begin
        errors++; $display("FAIL full_beat%0d got set=%0d row=%0d last=%b cyc=%0d data=%h want set=%0d row=%0d last=%b cyc=%0d data=%h",
          k, got[k].set, got[k].row, got[k].last, got[k].cyc - start_cyc, got[k].data,
          k / ROWS_PER_SET, k % ROWS_PER_SET, k == TOTAL - 1, 3 + k, exp_data(k / ROWS_PER_SET, k % ROWS_PER_SET));
      end
    end
    checks++;
    if (got.size() != TOTAL) begin errors++; $display("FAIL full_count got %0d want %0d", got.size(), TOTAL); end
    checks++;
    if (first_strobe_cyc != start_cyc + 1) begin
      errors++; $display("FAIL full_first_strobe got cyc %0d want 1", first_strobe_cyc - start_cyc);
    end
    checks++;
    if (busy_rise_cyc != start_cyc + 1) begin
      errors++; $display("FAIL full_busy_rise got cyc %0d want 1", busy_rise_cyc - start_cyc);
    end
    checks++;
    if (done_cyc != start_cyc + 3 + TOTAL || done_pulses != 1 || busy_at_done !== 1'b0) begin
      errors++; $display("FAIL full_done got cyc=%0d pulses=%0d busy=%b want cyc=%0d pulses=1 busy=0",
        done_cyc - start_cyc, done_pulses, busy_at_done, 3 + TOTAL);
    end
  endtask

  task automatic test_stall();
    bit to;
    int ec;
    fill_mem(1'b0);
    mon_clear();
    run_drain(1, to);
    checks++;
    if (to) begin errors++; $display("FAIL stall_timeout done not seen want done pulse"); end
    for (int k = 0; k < TOTAL; k++) begin
      ec = (k < 2) ? 3 + k : 8 + k;
      checks++;
      if (k >= got.size()) begin
        errors++; $display("FAIL stall_beat%0d missing got %0d beats want %0d", k, got.size(), TOTAL);
      end else if (got[k].set != k / ROWS_PER_SET || got[k].row != k % ROWS_PER_SET ||
                   got[k].cyc != start_cyc + ec ||
                   got[k].data !== exp_data(k / ROWS_PER_SET, k % ROWS_PER_SET)) begin
        errors++; $display("FAIL stall_beat%0d got set=%0d row=%0d cyc=%0d want set=%0d row=%0d cyc=%0d",
          k, got[k].set, got[k].row, got[k].cyc - start_cyc, k / ROWS_PER_SET, k % ROWS_PER_SET, ec);
      end
    end
    checks++;
    if (stable_err != 0 || credit_err != 0 || multi_err != 0 || got.size() != TOTAL) begin
      errors++; $display("FAIL stall_protocol unstable=%0d credit=%0d multi=%0d beats=%0d want 0/0/0/%0d",
        stable_err, credit_err, multi_err, got.size(), TOTAL);
    end
  endtask

  task automatic test_random_ready();
    bit to;
    for (int rep = 0; rep < 2; rep++) begin
      fill_mem(1'b0);
      mon_clear();
      run_drain(2, to);
      checks++;
      if (to) begin errors++; $display("FAIL rand%0d_timeout done not seen want done pulse", rep); end
      for (int k = 0; k < TOTAL; k++) begin
        checks++;
        if (k >= got.size()) begin
          errors++; $display("FAIL rand%0d_beat%0d missing got %0d want %0d", rep, k, got.size(), TOTAL);
        end else if (got[k].set != k / ROWS_PER_SET || got[k].row != k % ROWS_PER_SET ||
                     got[k].last !== (k == TOTAL - 1) ||
                     got[k].data !== exp_data(k / ROWS_PER_SET, k % ROWS_PER_SET)) begin
          errors++; $display("FAIL rand%0d_beat%0d got set=%0d row=%0d last=%b want set=%0d row=%0d last=%b",
            rep, k, got[k].set, got[k].row, got[k].last, k / ROWS_PER_SET, k % ROWS_PER_SET, k == TOTAL - 1);
        end
      end
      checks++;
      if (stable_err != 0 || credit_err != 0 || multi_err != 0 || got.size() != TOTAL || done_pulses != 1) begin
        errors++; $display("FAIL rand%0d_protocol unstable=%0d credit=%0d multi=%0d beats=%0d done=%0d want 0/0/0/%0d/1",
          rep, stable_err, credit_err, multi_err, got.size(), done_pulses, TOTAL);
      end
    end
  endtask

  task automatic test_restart_ignored();
    bit to;
    fill_mem(1'b0);
    mon_clear();
    run_drain(3, to);
    checks++;
    if (to) begin errors++; $display("FAIL restart_timeout done not seen want done pulse"); end
    for (int k = 0; k < TOTAL; k++) begin
      checks++;
      if (k >= got.size()) begin
        errors++; $display("FAIL restart_beat%0d missing got %0d want %0d", k, got.size(), TOTAL);
      end else if (got[k].set != k / ROWS_PER_SET || got[k].row != k % ROWS_PER_SET ||
                   got[k].cyc != start_cyc + 3 + k ||
                   got[k].data !== exp_data(k / ROWS_PER_SET, k % ROWS_PER_SET)) begin
        errors++; $display("FAIL restart_beat%0d got set=%0d row=%0d cyc=%0d want set=%0d row=%0d cyc=%0d",
          k, got[k].set, got[k].row, got[k].cyc - start_cyc, k / ROWS_PER_SET, k % ROWS_PER_SET, 3 + k);
      end
    end
    checks++;
    if (got.size() != TOTAL) begin errors++; $display("FAIL restart_count got %0d want %0d", got.size(), TOTAL); end
    // Let a wrongly re-armed drain show itself as extra strobes or beats.
    repeat (10) @(negedge clk);
    checks++;
    if (issued != TOTAL || got.size() != TOTAL || done_pulses != 1) begin
      errors++; $display("FAIL restart_after issued=%0d beats=%0d done=%0d want %0d/%0d/1",
        issued, got.size(), done_pulses, TOTAL, TOTAL);
    end
  endtask

  task automatic test_srst_abort();
    bit to;
    bit hit;
    fill_mem(1'b0);
    mon_clear();
    @(posedge clk); #1;
    drain_start = 1'b1;
    ifc.out_ready = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1;
      drain_start = 1'b0;
      if (accepted >= 20) begin hit = 1'b1; break; end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL srst_reach got %0d beats want 20", accepted); end
    srst = 1'b1;
    @(posedge clk); #1;
    srst = 1'b0;
    @(negedge clk);
    checks++;
    if ({sram_read_enable_a0, sram_read_enable_b0, sram_read_enable_c0} !== 3'b000 || sram_raddr !== '0 ||
        ifc.out_valid !== 1'b0 || ifc.out_data !== '0 || ifc.out_set !== 2'd0 || ifc.out_row !== '0 ||
        ifc.out_last !== 1'b0 || drain_busy !== 1'b0 || drain_done !== 1'b0) begin
      errors++; $display("FAIL srst_outputs strobes=%b raddr=%0d valid=%b set=%0d row=%0d busy=%b done=%b want all 0",
        {sram_read_enable_a0, sram_read_enable_b0, sram_read_enable_c0}, sram_raddr, ifc.out_valid,
        ifc.out_set, ifc.out_row, drain_busy, drain_done);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (drain_busy !== 1'b0 || ifc.out_valid !== 1'b0 || sram_read_enable_b0 !== 1'b0) begin
      errors++; $display("FAIL srst_idle busy=%b valid=%b strobe_b=%b want 0/0/0",
        drain_busy, ifc.out_valid, sram_read_enable_b0);
    end
    mon_clear();
    run_drain(0, to);
    checks++;
    if (to) begin errors++; $display("FAIL srst_redrain_timeout done not seen want done pulse"); end
    for (int k = 0; k < TOTAL; k++) begin
      checks++;
      if (k >= got.size()) begin
        errors++; $display("FAIL srst_beat%0d missing got %0d want %0d", k, got.size(), TOTAL);
      end else if (got[k].set != k / ROWS_PER_SET || got[k].row != k % ROWS_PER_SET ||
                   got[k].cyc != start_cyc + 3 + k ||
                   got[k].data !== exp_data(k / ROWS_PER_SET, k % ROWS_PER_SET)) begin
        errors++; $display("FAIL srst_beat%0d got set=%0d row=%0d cyc=%0d want set=%0d row=%0d cyc=%0d",
          k, got[k].set, got[k].row, got[k].cyc - start_cyc, k / ROWS_PER_SET, k % ROWS_PER_SET, 3 + k);
      end
    end
  endtask

`ifdef RESULT_DRAIN_SUM_EN
  task automatic test_sum();
    bit to;
    fill_mem(1'b1);
    mon_clear();
    run_drain(0, to);
    checks++;
    if (to || sum_at_done !== 32'hFFFF_FE98) begin
      errors++; $display("FAIL sum_all_ones got %h timeout=%b want fffffe98", sum_at_done, to);
    end
  endtask
`endif

  initial begin
    srst = 1'b1;
    drain_start = 1'b0;
    ifc.out_ready = 1'b0;
    test_reset();
    test_full_rate();
    test_stall();
    test_random_ready();
    test_restart_ignored();
    test_srst_abort();
`ifdef RESULT_DRAIN_SUM_EN
    test_sum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
